regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Owns the single-ported LC-3 general register file (8 x 16).
- Shares that one port between two requesters:
  - the decode stage, which fetches operands;
  - the writeback stage, which writes results.
- Sequences the register reads each opcode needs and returns the captured operands with a single done pulse.
- Arbitrates writes against reads and keeps captured operands coherent with writes that land mid-fetch.

Parameters:
- DATA_W, 16, register width.
- NREGS, 8, number of registers; address width is $clog2(NREGS).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dec_req  in  1  decode requests an operand fetch; level, held until dec_ack.
- dec_instr  in  16  instruction; stable while dec_req is high.
- dec_ack  out  1  one-cycle pulse; operand outputs are valid from this cycle and held until the next acceptance.
- sr1_val  out  16  operand from register dec_instr[8:6].
- sr2_val  out  16  operand from register dec_instr[2:0]; 0 when not read.
- imm_val  out  16  sign-extended dec_instr[4:0]; 0 when not immediate mode.
- dr_addr  out  3  dec_instr[11:9], captured at acceptance.
- is_imm  out  1  dec_instr[5] for ADD/AND, otherwise 0.
- wb_req  in  1  write request; level, held until wb_ack.
- wb_addr  in  3  write address.
- wb_data  in  16  write data.
- wb_ack  out  1  combinational grant; the write commits on the clock edge ending the cycle in which wb_ack is high.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, reset_n low):
  - state goes to IDLE.
  - All outputs go to 0.
  - All registers clear to 0.
  - Any fetch in flight is abandoned with no dec_ack.
- Register file timing:
  - Synchronous read: address is issued in cycle N, data is valid in cycle N+1.
  - Write commits at the edge.
  - Only one access (read issue or write) is allowed per cycle.
- Read plan, by opcode dec_instr[15:12]:
  - 0001 ADD, 0101 AND:
    - dec_instr[5]=0: read SR1 then SR2.
    - dec_instr[5]=1: read SR1 only; imm_val = {{11{i[4]}}, i[4:0]}.
  - 1001 NOT: read SR1 only.
  - Any other opcode: no reads; ack only.
- FSM states:
  - IDLE: accept when dec_req=1; latch the instruction and read plan. Next state is ISS1 if reads are needed, else ACK.
  - ISS1: issue SR1 address, then go to CAP1.
  - CAP1: capture rdata into sr1_val. Next state is ISS2 if SR2 is needed, else ACK.
  - ISS2: issue SR2 address, then go to CAP2.
  - CAP2: capture rdata into sr2_val, then go to ACK.
  - ACK: dec_ack=1 for exactly one cycle, then go to IDLE.
- Latency from the acceptance edge to dec_ack high, with no contention:
  - zero reads: 1 cycle;
  - one read: 3 cycles;
  - two reads: 5 cycles.
- Arbitration:
  - The port is free for writes in IDLE, CAP1, CAP2 and ACK.
  - In ISS1/ISS2, a write wins unless the previous cycle was already a write grant. This alternation bounds each read stall to 1 cycle.
  - A stalled ISSx holds its state and issues nothing.
- Coherence (forwarding):
  - If a write commits to register A after A's read was issued and before dec_ack, the captured operand for A takes wb_data.
  - This includes a write in the CAPx cycle for the address being captured: the capture takes wb_data, not rdata.
  - A write to A before A's ISS is simply read back from the array.
- Simultaneous dec_req and wb_req in IDLE: the write is granted; acceptance also occurs in the same cycle.
- sr1_val and sr2_val both read the same register: two independent reads; both values are coherent.
- dec_req dropped mid-fetch is a protocol violation. The fetch completes and acks anyway.
- Widths: imm sign extension is 5 to 16 bits; there is no other arithmetic.

Decomposition:
- Package lc3_pkg:
  - opcode constants OP_ADD=4'b0001, OP_AND=4'b0101, OP_NOT=4'b1001;
  - the fetch state enum;
  - a read-plan struct {need_sr1, need_sr2, is_imm}.
- Sub-module lc3_regfile:
  - single port, NREGS x DATA_W;
  - synchronous read, synchronous write;
  - async active-low clear.
- The controller holds the FSM, arbiter and forwarding logic.

Test Plan:
- Reset, then write R1=5 and R2=7 via wb, then request ADD R3,R1,R2 (0x1642) -> dec_ack 5 cycles after acceptance; sr1_val=5, sr2_val=7, dr_addr=3, is_imm=0.
- ADD R0,R1,#-3 (0x107D) -> ack after 3 cycles; sr1_val=5, imm_val=0xFFFD, is_imm=1, sr2_val=0.
- Opcode 0000 (BR) -> ack 1 cycle after acceptance; sr1/sr2/imm all 0.
- wb_req asserted continuously (R4 := 0x0100) during the two-read fetch of 0x1642 -> writes and reads alternate; each read stalls at most 1 cycle; ack ≤7 cycles after acceptance.
- Fetch 0x1642 with a write R2 := 0xBEEF in the CAP2 cycle -> sr2_val=0xBEEF; array R2=0xBEEF afterwards.
- Assert reset_n low during CAP1 -> no dec_ack; all outputs 0 and busy 0 immediately; subsequent reads of R1 return 0.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared LC-3 definitions for the register-file access controller:
// opcodes, fetch FSM states and the per-instruction read plan.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISS1,
    ST_CAP1,
    ST_ISS2,
    ST_CAP2,
    ST_ACK
  } fetch_state_e;

  typedef struct packed {
    logic need_sr1;
    logic need_sr2;
    logic is_imm;
  } read_plan_t;

  function automatic read_plan_t plan_of(input logic [15:0] instr);
    read_plan_t p;
    p = '0;
    case (instr[15:12])
      OP_ADD, OP_AND: begin
        p.need_sr1 = 1'b1;
        p.is_imm   = instr[5];
        p.need_sr2 = ~instr[5];
      end
      OP_NOT:  p.need_sr1 = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Decode-fetch and writeback handshakes of the register-file access controller.
interface regfile_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
);
  localparam int AW = $clog2(NREGS);

  logic              dec_req;
  logic [15:0]       dec_instr;
  logic              dec_ack;
  logic [DATA_W-1:0] sr1_val;
  logic [DATA_W-1:0] sr2_val;
  logic [DATA_W-1:0] imm_val;
  logic [2:0]        dr_addr;
  logic              is_imm;
  logic              wb_req;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack;
  logic              busy;

  modport master (
    output dec_req, dec_instr, wb_req, wb_addr, wb_data,
    input  dec_ack, sr1_val, sr2_val, imm_val, dr_addr, is_imm, wb_ack, busy
  );

  modport slave (
    input  dec_req, dec_instr, wb_req, wb_addr, wb_data,
    output dec_ack, sr1_val, sr2_val, imm_val, dr_addr, is_imm, wb_ack, busy
  );

endinterface

// File: rtl/regfile_access_ctrl_regfile.sv
// Single-ported NREGS x DATA_W register array: synchronous read and write,
// asynchronous active-low clear. Write takes priority if both are requested.
module lc3_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(NREGS)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      rdata <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch controller sharing the single register-file port between
// decode reads and writeback writes, with forwarding of mid-fetch writes.
module regfile_access_ctrl
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  regfile_access_ctrl_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  fetch_state_e      state, state_nxt;
  read_plan_t        new_plan;
  logic              accept;
  logic              need_sr2;
  logic              grant_last;
  logic              in_iss;
  logic              wb_grant;
  logic              rd_issue;
  logic              fwd_sr1;
  logic              fwd_sr2;
  logic              dec_ack;
  logic              busy;
  logic [AW-1:0]     sr1_addr;
  logic [AW-1:0]     sr2_addr;
  logic [AW-1:0]     rf_addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] sr1_val;
  logic [DATA_W-1:0] sr2_val;
  logic [DATA_W-1:0] imm_val;
  logic [2:0]        dr_addr;
  logic              is_imm;

  function automatic logic signed [DATA_W-1:0] sext_imm5(input logic signed [4:0] imm);
    return {{(DATA_W-5){imm[4]}}, imm};
  endfunction

  assign new_plan = plan_of(bus.dec_instr);
  assign accept   = (state == ST_IDLE) && bus.dec_req;

  // state register; grant_last remembers whether the port went to a write last cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant_last <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_last <= wb_grant;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.dec_req) state_nxt = new_plan.need_sr1 ? ST_ISS1 : ST_ACK;
      ST_ISS1: if (!wb_grant)   state_nxt = ST_CAP1;
      ST_CAP1: state_nxt = need_sr2 ? ST_ISS2 : ST_ACK;
      ST_ISS2: if (!wb_grant)   state_nxt = ST_CAP2;
      ST_CAP2: state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Issue cycles yield to a write only if the previous cycle was not a write,
  // so reads and a continuous write stream alternate.
  always_comb begin
    in_iss   = (state == ST_ISS1) || (state == ST_ISS2);
    wb_grant = bus.wb_req && !(in_iss && grant_last);
    rd_issue = in_iss && !wb_grant;
    rf_addr  = wb_grant ? bus.wb_addr : ((state == ST_ISS2) ? sr2_addr : sr1_addr);
    fwd_sr1  = wb_grant && (bus.wb_addr == sr1_addr);
    fwd_sr2  = wb_grant && (bus.wb_addr == sr2_addr);
    dec_ack  = (state == ST_ACK);
    busy     = (state != ST_IDLE);
  end

  lc3_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wb_grant),
    .re      (rd_issue),
    .addr    (rf_addr),
    .wdata   (bus.wb_data),
    .rdata   (rdata)
  );

  // operand capture; a write landing after an operand's read issue overrides it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr1_val  <= '0;
      sr2_val  <= '0;
      imm_val  <= '0;
      dr_addr  <= '0;
      is_imm   <= 1'b0;
      sr1_addr <= '0;
      sr2_addr <= '0;
      need_sr2 <= 1'b0;
    end else begin
      if (accept) begin
        sr1_val  <= '0;
        sr2_val  <= '0;
        imm_val  <= new_plan.is_imm ? sext_imm5(bus.dec_instr[4:0]) : '0;
        dr_addr  <= bus.dec_instr[11:9];
        is_imm   <= new_plan.is_imm;
        sr1_addr <= bus.dec_instr[6 +: AW];
        sr2_addr <= bus.dec_instr[0 +: AW];
        need_sr2 <= new_plan.need_sr2;
      end
      case (state)
        ST_CAP1: sr1_val <= fwd_sr1 ? bus.wb_data : rdata;
        ST_ISS2: if (fwd_sr1) sr1_val <= bus.wb_data;
        ST_CAP2: begin
          if (fwd_sr1) sr1_val <= bus.wb_data;
          sr2_val <= fwd_sr2 ? bus.wb_data : rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.dec_ack = dec_ack;
  assign bus.busy    = busy;
  assign bus.wb_ack  = wb_grant;
  assign bus.sr1_val = sr1_val;
  assign bus.sr2_val = sr2_val;
  assign bus.imm_val = imm_val;
  assign bus.dr_addr = dr_addr;
  assign bus.is_imm  = is_imm;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl: drivers queue expected fetches,
// a negedge monitor checks each dec_ack against a plain register-array model.
module tb_regfile_access_ctrl;

  typedef struct {
    logic [15:0] instr;
    int          accept_cyc;
    int          lat_min;
    int          lat_max;
  } item_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc     = 0;
  int          n_cmp   = 0;
  int          n_fail  = 0;
  logic [15:0] model_mem [8];
  item_t       exp_q [$];

  regfile_access_ctrl_if #(.DATA_W(16), .NREGS(8)) bus ();

  regfile_access_ctrl #(.DATA_W(16), .NREGS(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_lat(input int lat, input int lo, input int hi);
    n_cmp++;
    if (lat < lo || lat > hi) begin
      n_fail++;
      $display("FAIL ack_latency: got %0d cycles, required %0d..%0d (t=%0t)", lat, lo, hi, $time);
    end
  endtask

  function automatic int n_reads(input logic [15:0] instr);
    logic [3:0] op;
    op = instr[15:12];
    if (op == 4'h1 || op == 4'h5) return instr[5] ? 1 : 2;
    if (op == 4'h9) return 1;
    return 0;
  endfunction

  // Monitor: operands must equal the register contents as of the ack cycle.
  always @(negedge clock) begin
    item_t       it;
    logic [3:0]  op;
    bit          alu, immm, rd1, rd2;
    int          v;
    logic [15:0] e_sr1, e_sr2, e_imm;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) model_mem[i] = 16'h0;
    end else begin
      if (bus.dec_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack: got dec_ack=1, required 0 (t=%0t)", $time);
        end else begin
          it    = exp_q.pop_front();
          op    = it.instr[15:12];
          alu   = (op == 4'h1) || (op == 4'h5);
          immm  = alu && it.instr[5];
          rd1   = alu || (op == 4'h9);
          rd2   = alu && !immm;
          e_sr1 = rd1 ? model_mem[it.instr[8:6]] : 16'h0;
          e_sr2 = rd2 ? model_mem[it.instr[2:0]] : 16'h0;
          v     = int'(it.instr[4:0]);
          if (v >= 16) v = v - 32;
          e_imm = immm ? 16'(v) : 16'h0;
          check_lat(cyc - it.accept_cyc, it.lat_min, it.lat_max);
          check("sr1_val", bus.sr1_val, e_sr1);
          check("sr2_val", bus.sr2_val, e_sr2);
          check("imm_val", bus.imm_val, e_imm);
          check("dr_addr", bus.dr_addr, it.instr[11:9]);
          check("is_imm",  bus.is_imm,  immm);
        end
      end
      if (bus.wb_ack) model_mem[bus.wb_addr] = bus.wb_data;
    end
  end

  task automatic fetch(input logic [15:0] instr, input bit contended);
    item_t it;
    int    nr;
    bit    got;
    nr = n_reads(instr);
    @(negedge clock);
    bus.dec_req   = 1'b1;
    bus.dec_instr = instr;
    it.instr      = instr;
    it.accept_cyc = cyc;
    it.lat_min    = 1 + 2 * nr;
    it.lat_max    = it.lat_min + (contended ? nr : 0);
    exp_q.push_back(it);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (bus.dec_ack) got = 1'b1;
    end
    bus.dec_req = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fetch_timeout: got no dec_ack for 0x%04h, required one within 20 cycles", instr);
      exp_q.delete();
    end
  endtask

  // Caller is just after a rising edge; holds wb_req until n grants are seen.
  task automatic do_stream(input logic [2:0] addr, input logic [15:0] data, input int n);
    bit got;
    bus.wb_req  = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clock);
        if (bus.wb_ack) got = 1'b1;
      end
      if (!got) begin
        n_cmp++;
        n_fail++;
        $display("FAIL write_timeout: got no wb_ack for R%0d, required one within 20 cycles", addr);
      end
      @(posedge clock);
      #1;
    end
    bus.wb_req = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
    do_stream(addr, data, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dec_ack"}, bus.dec_ack, 0);
    check({tag, "_busy"},    bus.busy,    0);
    check({tag, "_wb_ack"},  bus.wb_ack,  0);
    check({tag, "_sr1"},     bus.sr1_val, 0);
    check({tag, "_sr2"},     bus.sr2_val, 0);
    check({tag, "_imm"},     bus.imm_val, 0);
    check({tag, "_dr"},      bus.dr_addr, 0);
    check({tag, "_is_imm"},  bus.is_imm,  0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] instr;
    int          sel, nw;
    bus.dec_req   = 1'b0;
    bus.dec_instr = 16'h0;
    bus.wb_req    = 1'b0;
    bus.wb_addr   = 3'd0;
    bus.wb_data   = 16'h0;

    repeat (3) @(negedge clock);
    check_idle("in_reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("after_reset");

    @(posedge clock);
    #1;
    do_write(3'd1, 16'd5);
    do_write(3'd2, 16'd7);

    fetch(16'h1642, 1'b0);
    check("add_sr1", bus.sr1_val, 16'd5);
    check("add_sr2", bus.sr2_val, 16'd7);
    check("add_dr",  bus.dr_addr, 3'd3);

    fetch(16'h107D, 1'b0);
    check("addi_imm",    bus.imm_val, 16'hFFFD);
    check("addi_is_imm", bus.is_imm,  1'b1);
    check("addi_sr2",    bus.sr2_val, 16'h0);

    fetch(16'h0000, 1'b0);
    check("br_sr1", bus.sr1_val, 16'h0);
    fetch(16'h1241, 1'b0);

    fork
      fetch(16'h1642, 1'b1);
      begin
        @(posedge clock);
        #1;
        do_stream(3'd4, 16'h0100, 12);
      end
    join
    fetch(16'h1104, 1'b0);
    check("r4_stream", bus.sr1_val, 16'h0100);

    fork
      fetch(16'h1642, 1'b0);
      begin
        @(negedge clock);
        repeat (4) @(posedge clock);
        #1;
        do_write(3'd2, 16'hBEEF);
      end
    join
    check("cap2_fwd_sr2", bus.sr2_val, 16'hBEEF);
    fetch(16'h1642, 1'b0);
    check("r2_after_fwd", bus.sr2_val, 16'hBEEF);

    @(negedge clock);
    bus.dec_req   = 1'b1;
    bus.dec_instr = 16'h1642;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n     = 1'b0;
    bus.dec_req = 1'b0;
    #1;
    check_idle("cap1_reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    fetch(16'h907F, 1'b0);
    check("r1_cleared", bus.sr1_val, 16'h0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 4);
      instr = 16'($urandom);
      case (sel)
        0: instr[15:12] = 4'h1;
        1: instr[15:12] = 4'h5;
        2: instr[15:12] = 4'h9;
        default: ;
      endcase
      nw = $urandom_range(0, 3);
      fork
        fetch(instr, nw > 0);
        begin
          @(negedge clock);
          for (int k = 0; k < nw; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            @(posedge clock);
            #1;
            do_write(3'($urandom_range(0, 7)), 16'($urandom));
          end
        end
      join
    end

    repeat (5) @(negedge clock);
    check("pending_fetches", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
